// File: rtl/md5_bf_pkg.sv
// Shared types for the MD5 brute-force job scheduler: controller states,
// message/hash widths and the target-hash word layout.
package md5_bf_pkg;

  localparam int MD5_BLOCK_W = 512;
  localparam int HASH_W      = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_RUN,
    ST_FOUND,
    ST_EXHAUSTED
  } bf_state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
  } md5_hash_t;

endpackage

// File: rtl/md5_bf_prio_pick.sv
// Lowest-set-bit priority encoder: valid when any request is set, idx is the
// lowest requesting position.
module md5_bf_prio_pick #(
  parameter int W     = 4,
  parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/md5_bf_job_scheduler.sv
// Dispatches keyspace prefix jobs to a bank of MD5 brute-force cores, latches
// the first match and aborts the bank, or flags exhaustion of the keyspace.
//
// state        | meaning
// ST_IDLE      | waiting for start; results of last search held
// ST_DISPATCH  | handing out prefixes to idle cores, one per cycle
// ST_RUN       | all prefixes issued, waiting for outstanding jobs
// ST_FOUND     | match latched; abort pulse to all cores
// ST_EXHAUSTED | every job finished without a match
module md5_bf_job_scheduler
  import md5_bf_pkg::*;
#(
  parameter int NUM_CORES    = 4,
  parameter int PREFIX_W     = 8,
  parameter int NUM_PREFIXES = 64,
  parameter int SYMB_W       = 4,
  localparam int CORE_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [31:0]                   a_MD5_hash,
  input  logic [31:0]                   b_MD5_hash,
  input  logic [31:0]                   c_MD5_hash,
  input  logic [31:0]                   d_MD5_hash,
  output logic [HASH_W-1:0]             core_hash,
  output logic [NUM_CORES-1:0]          core_start,
  output logic [PREFIX_W-1:0]           core_prefix,
  output logic                          core_abort,
  input  logic [NUM_CORES-1:0]          core_done,
  input  logic [NUM_CORES-1:0]          core_found,
  input  logic [NUM_CORES*MD5_BLOCK_W-1:0] core_result,
  input  logic [NUM_CORES*SYMB_W-1:0]   core_symb,
  output logic                          find_str,
  output logic [MD5_BLOCK_W-1:0]        result_str,
  output logic [SYMB_W-1:0]             symb_count,
  output logic [CORE_W-1:0]             found_core,
  output logic                          end_brute_force,
  output logic                          busy
);

  localparam logic [PREFIX_W:0] PREFIX_END = (PREFIX_W + 1)'(NUM_PREFIXES);

  bf_state_t            state, state_n;
  logic [PREFIX_W:0]    next_prefix;
  logic [NUM_CORES-1:0] active;
  logic                 rst_q;
  logic                 abort_rst;
  logic                 idle_vld, found_vld;
  logic [CORE_W-1:0]    idle_idx, found_idx;
  logic                 dispatch;
  md5_hash_t            hash_in;

  assign hash_in = '{a: a_MD5_hash, b: b_MD5_hash, c: c_MD5_hash, d: d_MD5_hash};

  md5_bf_prio_pick #(.W(NUM_CORES), .IDX_W(CORE_W)) u_idle_pick (
    .req   (~active),
    .valid (idle_vld),
    .idx   (idle_idx)
  );

  md5_bf_prio_pick #(.W(NUM_CORES), .IDX_W(CORE_W)) u_found_pick (
    .req   (core_found),
    .valid (found_vld),
    .idx   (found_idx)
  );

  // A match in this cycle suppresses any dispatch in the same cycle.
  assign dispatch = (state == ST_DISPATCH) && !found_vld && idle_vld &&
                    (next_prefix < PREFIX_END);
  assign busy     = (state == ST_DISPATCH) || (state == ST_RUN);

  always_comb begin
    state_n     = state;
    core_start  = '0;
    core_prefix = '0;
    core_abort  = abort_rst;
    case (state)
      ST_IDLE: begin
        if (start) state_n = ST_DISPATCH;
      end
      ST_DISPATCH: begin
        if (found_vld) begin
          state_n = ST_FOUND;
        end else begin
          if (dispatch) begin
            core_start  = NUM_CORES'(1) << idle_idx;
            core_prefix = next_prefix[PREFIX_W-1:0];
          end
          if (next_prefix == PREFIX_END) state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (found_vld)        state_n = ST_FOUND;
        else if (active == '0) state_n = ST_EXHAUSTED;
      end
      ST_FOUND: begin
        core_abort = 1'b1;
        state_n    = ST_IDLE;
      end
      ST_EXHAUSTED: state_n = ST_IDLE;
      default:      state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      next_prefix     <= '0;
      active          <= '0;
      core_hash       <= '0;
      find_str        <= 1'b0;
      end_brute_force <= 1'b0;
      result_str      <= '0;
      symb_count      <= '0;
      found_core      <= '0;
      rst_q           <= 1'b1;
      abort_rst       <= 1'b0;
    end else begin
      state     <= state_n;
      rst_q     <= 1'b0;
      // cores may still hold jobs from before the reset; flush them once
      abort_rst <= rst_q;
      case (state)
        ST_IDLE: begin
          if (start) begin
            core_hash       <= hash_in;
            find_str        <= 1'b0;
            end_brute_force <= 1'b0;
            result_str      <= '0;
            symb_count      <= '0;
            found_core      <= '0;
            next_prefix     <= '0;
            active          <= '0;
          end
        end
        ST_DISPATCH, ST_RUN: begin
          if (found_vld) begin
            find_str   <= 1'b1;
            result_str <= core_result[int'(found_idx)*MD5_BLOCK_W +: MD5_BLOCK_W];
            symb_count <= core_symb[int'(found_idx)*SYMB_W +: SYMB_W];
            found_core <= found_idx;
          end else begin
            active <= (active & ~core_done) | core_start;
            if (dispatch) next_prefix <= next_prefix + 1'b1;
          end
        end
        ST_FOUND:     active          <= '0;
        ST_EXHAUSTED: end_brute_force <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
